// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - RTC bus arbiter: read/write engine ownership, turnaround, refresh tick.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rtc_bus_arbiter #(
    parameter int TURN_CYC    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_rd,
    input  logic       done_rd,
    input  logic       req_wr,
    input  logic       done_wr,
    output logic       gnt_rd,
    output logic       gnt_wr,
    input  logic       rd_ad,
    input  logic       rd_cs,
    input  logic       rd_rd,
    input  logic       rd_wr,
    input  logic [7:0] rd_dout,
    input  logic       rd_oe,
    input  logic       wr_ad,
    input  logic       wr_cs,
    input  logic       wr_rd,
    input  logic       wr_wr,
    input  logic [7:0] wr_dout,
    input  logic       wr_oe,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       refresh_tick,
    output logic       busy,
    output logic       timeout_err
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR, TURN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_wr;
    logic [3:0]       turn_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic             in_grant;
    logic             done_own;
    logic             force_rel;
    logic             release_now;

    assign in_grant    = (state == GRANT_RD) || (state == GRANT_WR);
    assign done_own    = ((state == GRANT_RD) && done_rd) || ((state == GRANT_WR) && done_wr);
    assign release_now = done_own || force_rel;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] wdog;

    assign force_rel = in_grant && !done_own && (wdog == TMO_W'(TIMEOUT_CYC - 1));

    // Counts cycles of the current grant; sits at zero outside GRANT so each grant starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            wdog        <= (in_grant && !release_now) ? wdog + 1'b1 : '0;
            timeout_err <= force_rel;
        end
    end
`else
    assign force_rel   = 1'b0;
    // The watchdog limit has no effect without the watchdog.
    assign timeout_err = (TIMEOUT_CYC < 1) ? 1'b0 : 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_rd && req_wr) begin
                    state_nxt = last_wr ? GRANT_RD : GRANT_WR;
                end else if (req_rd) begin
                    state_nxt = GRANT_RD;
                end else if (req_wr) begin
                    state_nxt = GRANT_WR;
                end
            end
            GRANT_RD, GRANT_WR: begin
                if (release_now) begin
                    state_nxt = TURN;
                end
            end
            TURN: begin
                if (turn_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_rd = (state == GRANT_RD);
        gnt_wr = (state == GRANT_WR);
        busy   = (state != IDLE);
    end

    // Turnaround length and round-robin memory are captured at the moment of release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_cnt <= 4'd0;
            last_wr  <= 1'b0;
        end else if (release_now) begin
            turn_cnt <= 4'(TURN_CYC - 1);
            last_wr  <= (state == GRANT_WR);
        end else if ((state == TURN) && (turn_cnt != 4'd0)) begin
            turn_cnt <= turn_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign refresh_tick = (ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {AD, CS, RD, WR} <= 4'hF;
            data_out         <= 8'h00;
            data_oe          <= 1'b0;
        end else if (gnt_rd) begin
            {AD, CS, RD, WR} <= {rd_ad, rd_cs, rd_rd, rd_wr};
            data_out         <= rd_dout;
            data_oe          <= rd_oe;
        end else if (gnt_wr) begin
            {AD, CS, RD, WR} <= {wr_ad, wr_cs, wr_rd, wr_wr};
            data_out         <= wr_dout;
            data_oe          <= wr_oe;
        end else begin
            {AD, CS, RD, WR} <= 4'hF;
            data_out         <= 8'h00;
            data_oe          <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - randomized self-checking bench for rtc_bus_arbiter.
module tb_rtc_bus_arbiter;

    localparam int TURN = 4;
    localparam int DIV  = 5;
    localparam int TMO  = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_rd, done_rd, req_wr, done_wr;
    logic       gnt_rd, gnt_wr;
    logic       rd_ad, rd_cs, rd_rd, rd_wr, rd_oe;
    logic       wr_ad, wr_cs, wr_rd, wr_wr, wr_oe;
    logic [7:0] rd_dout, wr_dout;
    logic       AD, CS, RD, WR;
    logic [7:0] data_out;
    logic       data_oe, refresh_tick, busy, timeout_err;

    always #5 clk = ~clk;

    rtc_bus_arbiter #(.TURN_CYC(TURN), .REFRESH_DIV(DIV), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .done_rd(done_rd), .req_wr(req_wr), .done_wr(done_wr),
        .gnt_rd(gnt_rd), .gnt_wr(gnt_wr),
        .rd_ad(rd_ad), .rd_cs(rd_cs), .rd_rd(rd_rd), .rd_wr(rd_wr),
        .rd_dout(rd_dout), .rd_oe(rd_oe),
        .wr_ad(wr_ad), .wr_cs(wr_cs), .wr_rd(wr_rd), .wr_wr(wr_wr),
        .wr_dout(wr_dout), .wr_oe(wr_oe),
        .AD(AD), .CS(CS), .RD(RD), .WR(WR),
        .data_out(data_out), .data_oe(data_oe),
        .refresh_tick(refresh_tick), .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: cycle index since reset, current owner (0 none, 1 rd, 2 wr),
    // earliest cycle at which a pending request may be decided.
    int         k, owner, last, eval_from, gcount;
    int         exp_toerr_cnt, obs_toerr_cnt, wr_grants_seen;
    logic       e_toerr;
    logic [3:0] e_str;
    logic [7:0] e_dout;
    logic       e_oe;

    task automatic model_reset();
        k = 0; owner = 0; last = 1; eval_from = 0; gcount = 0;
        e_toerr = 1'b0; e_str = 4'hF; e_dout = 8'h00; e_oe = 1'b0;
    endtask

    task automatic model_advance();
        logic rel;
        if (owner == 1) begin
            e_str = {rd_ad, rd_cs, rd_rd, rd_wr}; e_dout = rd_dout; e_oe = rd_oe;
        end else if (owner == 2) begin
            e_str = {wr_ad, wr_cs, wr_rd, wr_wr}; e_dout = wr_dout; e_oe = wr_oe;
        end else begin
            e_str = 4'hF; e_dout = 8'h00; e_oe = 1'b0;
        end
        e_toerr = 1'b0;
        if (owner != 0) begin
            rel = (owner == 1) ? done_rd : done_wr;
            if (!rel && TMO_EN && gcount == TMO - 1) begin
                rel = 1'b1;
                e_toerr = 1'b1;
                exp_toerr_cnt++;
            end
            if (rel) begin
                last = owner; owner = 0; eval_from = k + 1 + TURN;
            end else begin
                gcount++;
            end
        end else if (k >= eval_from) begin
            if (req_rd && req_wr) owner = (last == 1) ? 2 : 1;
            else if (req_rd)      owner = 1;
            else if (req_wr)      owner = 2;
            gcount = 0;
        end
        k++;
    endtask

    task automatic check_all();
        check("gnt_rd", gnt_rd, owner == 1);
        check("gnt_wr", gnt_wr, owner == 2);
        check("gnt_excl", gnt_rd & gnt_wr, 0);
        check("busy", busy, (owner != 0) || (k < eval_from));
        check("refresh_tick", refresh_tick, (k % DIV) == DIV - 1);
        check("timeout_err", timeout_err, e_toerr);
        check("strobes", {AD, CS, RD, WR}, e_str);
        check("data_out", data_out, e_dout);
        check("data_oe", data_oe, e_oe);
        if (timeout_err === 1'b1) obs_toerr_cnt++;
    endtask

    task automatic step();
        model_advance();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_pins();
        {rd_ad, rd_cs, rd_rd, rd_wr, rd_oe} = 5'($urandom);
        {wr_ad, wr_cs, wr_rd, wr_wr, wr_oe} = 5'($urandom);
        rd_dout = 8'($urandom);
        wr_dout = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        {req_rd, done_rd, req_wr, done_wr} = 4'b0;
        {rd_ad, rd_cs, rd_rd, rd_wr, rd_oe} = 5'b11110;
        {wr_ad, wr_cs, wr_rd, wr_wr, wr_oe} = 5'b11110;
        rd_dout = 8'h00; wr_dout = 8'h00;
        exp_toerr_cnt = 0; obs_toerr_cnt = 0; wr_grants_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();

        // Write grant with CS low, then reset in the middle of a cycle.
        req_wr = 1'b1; wr_cs = 1'b0; wr_oe = 1'b1; wr_dout = 8'hA5;
        repeat (4) step();
        check("pre_rst_cs", CS, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_cs", CS, 1'b1);
        check("rst_oe", data_oe, 1'b0);
        check("rst_gnt_wr", gnt_wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        req_wr = 1'b0; wr_cs = 1'b1; wr_oe = 1'b0;
        rst = 1'b0;
        model_reset();
        check_all();

        // Read only, done 10 cycles into the grant; refresh ticks checked every cycle.
        req_rd = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rand_pins();
            done_rd = (owner == 1 && gcount == 9);
            if (done_rd) req_rd = 1'b0;
            step();
        end
        done_rd = 1'b0;

        // Both held: round-robin, each owner releases after 3 cycles.
        req_rd = 1'b1; req_wr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rand_pins();
            done_rd = (owner == 1 && gcount == 2);
            done_wr = (owner == 2 && gcount == 2) || (owner == 1 && gcount == 1);
            if (gnt_wr && owner == 2 && gcount == 0) wr_grants_seen++;
            step();
        end
        check("alternation_wr_grants", wr_grants_seen >= 3, 1);
        {done_rd, done_wr, req_rd, req_wr} = 4'b0;
        repeat (TURN + 2) step();

        // Read grant with no done, request dropped: held (or watchdog-released).
        req_rd = 1'b1;
        for (int i = 0; i < 45; i++) begin
            rand_pins();
            if (i == 5) req_rd = 1'b0;
            if (i == 8) req_wr = 1'b1;
            done_wr = (owner == 1) && ($urandom_range(0, 2) == 0);
            step();
        end
        {done_rd, done_wr, req_rd, req_wr} = 4'b0;
        done_rd = 1'b1;
        step();
        done_rd = 1'b0;
        repeat (TURN + 2) step();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rand_pins();
            req_rd  = ($urandom_range(0, 3) != 0);
            req_wr  = ($urandom_range(0, 3) != 0);
            done_rd = ($urandom_range(0, 9) == 0);
            done_wr = ($urandom_range(0, 9) == 0);
            step();
        end

        check("timeout_pulses", obs_toerr_cnt, exp_toerr_cnt);
        if (TMO_EN) check("timeout_seen", exp_toerr_cnt > 0, 1);
        else        check("no_timeout", obs_toerr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the single multiplexed RTC bus (AD, CS, RD, WR, 8-bit data) between the periodic time-read engine (display refresh) and the write/programming engine.
- Grants exclusive bus ownership per transaction and muxes the granted engine's strobes and data onto the pins.
- Inserts bus-idle turnaround cycles between owners.
- Generates the periodic refresh tick that triggers the read engine.

Parameters:
- TURN_CYC, 4, idle cycles forced on the bus after every release (1..15).
- REFRESH_DIV, 100000, clk cycles per refresh_tick (at least 2).
- TIMEOUT_CYC, 4096, grant watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req_rd  in  1  read engine request; level, held until done_rd.
- done_rd  in  1  read engine transaction-complete pulse.
- req_wr  in  1  write engine request; level.
- done_wr  in  1  write engine transaction-complete pulse.
- gnt_rd  out  1  read engine owns the bus.
- gnt_wr  out  1  write engine owns the bus.
- rd_ad, rd_cs, rd_rd, rd_wr  in  1 each  read engine strobes (active-low).
- rd_dout  in  8  read engine drive data.
- rd_oe  in  1  read engine data drive enable.
- wr_ad, wr_cs, wr_rd, wr_wr  in  1 each  write engine strobes (active-low).
- wr_dout  in  8  write engine drive data.
- wr_oe  in  1  write engine data drive enable.
- AD, CS, RD, WR  out  1 each  RTC bus strobes (active-low).
- data_out  out  8  bus data.
- data_oe  out  1  bus tristate enable.
- refresh_tick  out  1  one-cycle pulse every REFRESH_DIV cycles.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  watchdog release pulse.

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state IDLE; gnt_rd=0, gnt_wr=0, busy=0, refresh_tick=0, timeout_err=0.
  - AD=CS=RD=WR=1, data_out=0, data_oe=0.
  - Refresh counter 0; last_owner=RD.
- Bus outputs are registered. Each cycle:
  - gnt_rd=1: pins take rd_* values.
  - gnt_wr=1: pins take wr_* values.
  - Otherwise: idle levels (all strobes 1, data_oe=0, data_out=0).
- States:
  - IDLE:
    - Only req_rd: go to GRANT_RD.
    - Only req_wr: go to GRANT_WR.
    - Both pending: grant the engine that is not last_owner, i.e. round-robin. After reset, the first tie goes to write.
    - The grant asserts the cycle after the request is sampled, so request-to-grant latency is 1 cycle.
  - GRANT_RD / GRANT_WR:
    - Hold the grant until the owner's done pulse.
    - On done: clear grant the next cycle, set last_owner, load the turnaround counter, go to TURN.
    - The other engine's done, or done while ungranted, is ignored.
    - Owner dropping req without done does not release the grant.
  - TURN:
    - Bus idle for exactly TURN_CYC cycles, then IDLE.
    - Requests arriving here are held pending and evaluated in IDLE.
    - Minimum release-to-next-grant gap is TURN_CYC+1 cycles.
- gnt_rd and gnt_wr are never both 1. There is never a cycle with a grant inside TURN.
- Refresh counter:
  - Free-runs 0..REFRESH_DIV-1 and wraps.
  - refresh_tick=1 for the cycle the counter equals REFRESH_DIV-1.
  - Independent of arbitration state.
- Reset mid-transaction: immediate idle pin levels, grants dropped asynchronously, counter restarts.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in either GRANT state.
  - On reaching TIMEOUT_CYC without done: force release exactly as if done had arrived (TURN, last_owner updated).
  - Pulse timeout_err for 1 cycle.
  - The watchdog clears on every grant.
- Undefined:
  - No watchdog; the grant is held indefinitely.
  - timeout_err is constant 0.

Test Plan:
- Reset with rst pulsed mid-GRANT_WR (wr_cs=0) -> CS=1, data_oe=0, gnt_wr=0 within the same cycle; after release, IDLE, with refresh_tick first pulsing at cycle REFRESH_DIV-1.
- req_rd only, done_rd 10 cycles after grant -> gnt_rd rises 1 cycle after req; pins follow rd_* one cycle later; gnt_rd falls the cycle after done; next grant no earlier than TURN_CYC+1=5 cycles later.
- req_rd and req_wr raised together after reset -> write granted first, then read after turnaround; repeat both pending -> strict alternation W,R,W,R.
- done_wr pulsed during GRANT_RD, and req_rd dropped without done -> gnt_rd stays 1, pins unchanged.
- REFRESH_DIV=5 override -> refresh_tick high at cycles 4, 9, 14, exactly one cycle each, regardless of grants.
- With ARB_TIMEOUT_EN, TIMEOUT_CYC=16, grant without done -> release after 16 grant cycles; timeout_err pulses once; other engine granted after turnaround. Without the macro -> grant persists and timeout_err=0.
